column_fill_tracker: RTL and testbench

Parametrised per-column fill counter for the Connect4 board: tracks how many pieces sit in each of NUM_COLS columns, each capped at ROWS. Drop and undo requests arrive as level signals from the debounced button logic and are edge-detected internally. Full-column, empty-column and malformed requests are rejected. It feeds the board-drawing and win-check logic with packed counts, the landing row and full flags.

---
 rtl/c4_pkg.sv | 25 ++
 rtl/rise_detect.sv | 19 +
 rtl/column_fill_tracker.sv | 123 ++++++++++++
 tb/tb_column_fill_tracker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Connect4 board defaults and helpers for decoding the active-low one-hot column select.
package c4_pkg;

    localparam int C4_COLS     = 4;
    localparam int C4_ROWS     = 6;
    localparam int C4_MAX_COLS = 16;

    // Callers pad unused upper bits with 1 so they never count as selected.
    function automatic logic onehot_low_valid(input logic [C4_MAX_COLS-1:0] vec);
        int zeros;
        zeros = 0;
        for (int i = 0; i < C4_MAX_COLS; i++)
            if (!vec[i]) zeros++;
        return (zeros == 1);
    endfunction

    function automatic logic [3:0] onehot_low_index(input logic [C4_MAX_COLS-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < C4_MAX_COLS; i++)
            if (!vec[i]) idx = 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level request; the history register resets high so a
// level held through reset release is not treated as a new request.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) level_q <= 1'b1;
        else        level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/column_fill_tracker.sv
// Per-column piece counters for the Connect4 board with edge-detected drop/undo,
// rejection of illegal requests, landing row and full flags.
module column_fill_tracker
    import c4_pkg::*;
#(
    parameter  int NUM_COLS = C4_COLS,
    parameter  int ROWS     = C4_ROWS,
    localparam int CW       = $clog2(ROWS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_COLS-1:0]    column,
    input  logic                   add,
    input  logic                   undo,
    input  logic                   clear,
    output logic [NUM_COLS*CW-1:0] count,
    output logic [CW-1:0]          row,
    output logic                   accept,
    output logic                   reject,
    output logic [NUM_COLS-1:0]    col_full,
    output logic                   board_full
);

    localparam int          IW   = $clog2(NUM_COLS);
    localparam logic [CW-1:0] FULL = CW'(ROWS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic                          add_edge, undo_edge;
    logic [NUM_COLS-1:0][CW-1:0]   cnt;
    logic [C4_MAX_COLS-1:0]        col_pad;
    logic [3:0]                    idx_full;
    logic [IW-1:0]                 sel_idx;
    logic                          sel_ok;
    logic [CW-1:0]                 sel_cnt;
    logic                          inc, dec, acc_n, rej_n, row_we;
    logic [CW-1:0]                 row_n;

    rise_detect u_add_rd (
        .clk   (clk),
        .reset (reset),
        .level (add),
        .pulse (add_edge)
    );

    rise_detect u_undo_rd (
        .clk   (clk),
        .reset (reset),
        .level (undo),
        .pulse (undo_edge)
    );

    // Shared decode: one request per cycle, applied to the selected column only.
    always_comb begin
        col_pad                 = '1;
        col_pad[NUM_COLS-1:0]   = column;
        sel_ok                  = onehot_low_valid(col_pad);
        idx_full                = onehot_low_index(col_pad);
        sel_idx                 = idx_full[IW-1:0];
        sel_cnt                 = cnt[sel_idx];
        inc    = 1'b0;
        dec    = 1'b0;
        acc_n  = 1'b0;
        rej_n  = 1'b0;
        row_we = 1'b0;
        row_n  = '0;
        if (clear) begin
            row_we = 1'b1;
        end else if (add_edge && undo_edge) begin
            rej_n = 1'b1;
        end else if (add_edge) begin
            if (!sel_ok || sel_cnt == FULL) begin
                rej_n = 1'b1;
            end else begin
                inc    = 1'b1;
                acc_n  = 1'b1;
                row_we = 1'b1;
                row_n  = sel_cnt;
            end
        end else if (undo_edge) begin
            if (!sel_ok || sel_cnt == '0) begin
                rej_n = 1'b1;
            end else begin
                dec    = 1'b1;
                acc_n  = 1'b1;
                row_we = 1'b1;
                row_n  = sel_cnt - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row    <= '0;
            accept <= 1'b0;
            reject <= 1'b0;
        end else begin
            accept <= acc_n;
            reject <= rej_n;
            if (row_we) row <= row_n;
        end
    end

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
        logic [CW-1:0] c;
        logic          hit;

        assign hit = (sel_idx == IW'(i));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)           c <= '0;
            else if (clear)       c <= '0;
            else if (inc && hit)  c <= c + ONE;
            else if (dec && hit)  c <= c - ONE;
        end

        assign cnt[i]      = c;
        assign col_full[i] = (c == FULL);
    end

    assign count      = cnt;
    assign board_full = &col_full;

endmodule

// File: tb/tb_column_fill_tracker.sv
// Directed bench for column_fill_tracker at the default 4x6 board.
module tb_column_fill_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  column;
    logic        add, undo, clear;
    logic [11:0] count;
    logic [2:0]  row;
    logic        accept, reject;
    logic [3:0]  col_full;
    logic        board_full;

    int checks   = 0;
    int failures = 0;

    column_fill_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .column     (column),
        .add        (add),
        .undo       (undo),
        .clear      (clear),
        .count      (count),
        .row        (row),
        .accept     (accept),
        .reject     (reject),
        .col_full   (col_full),
        .board_full (board_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] col, input logic a, input logic u);
        column = col;
        add    = a;
        undo   = u;
        tick();
    endtask

    task automatic idle();
        add  = 1'b0;
        undo = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; column = 4'hF; add = 1'b0; undo = 1'b0; clear = 1'b0;
        repeat (3) tick();
        checks++;
        if (count !== 12'h000 || row !== 3'd0 || accept !== 1'b0 || reject !== 1'b0 ||
            col_full !== 4'h0 || board_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state count=%h row=%0d acc=%b rej=%b full=%b bfull=%b want all 0",
                     count, row, accept, reject, col_full, board_full);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_add_col0();
        for (int k = 0; k < 3; k++) begin
            req(4'b1110, 1'b1, 1'b0);
            checks++;
            if (accept !== 1'b1 || reject !== 1'b0 || row !== 3'(k)) begin
                failures++;
                $display("FAIL add_col0_%0d acc=%b rej=%b row=%0d want acc=1 rej=0 row=%0d",
                         k, accept, reject, row, k);
            end
            idle();
            idle();
        end
        checks++;
        if (count !== 12'h003 || accept !== 1'b0) begin
            failures++;
            $display("FAIL add_col0_count count=%h acc=%b want 003 acc=0", count, accept);
        end
    endtask

    task automatic test_fill_col3();
        for (int k = 0; k < 6; k++) begin
            req(4'b0111, 1'b1, 1'b0);
            checks++;
            if (accept !== 1'b1 || row !== 3'(k)) begin
                failures++;
                $display("FAIL fill_col3_%0d acc=%b row=%0d want acc=1 row=%0d", k, accept, row, k);
            end
            idle();
        end
        checks++;
        if (count !== 12'hC03 || col_full !== 4'b1000 || board_full !== 1'b0) begin
            failures++;
            $display("FAIL col3_full count=%h full=%b bfull=%b want C03 1000 0",
                     count, col_full, board_full);
        end
        req(4'b0111, 1'b1, 1'b0);
        checks++;
        if (reject !== 1'b1 || accept !== 1'b0 || count !== 12'hC03) begin
            failures++;
            $display("FAIL col3_overfill rej=%b acc=%b count=%h want rej=1 acc=0 C03",
                     reject, accept, count);
        end
        idle();
        checks++;
        if (reject !== 1'b0) begin
            failures++;
            $display("FAIL reject_one_cycle rej=%b want 0", reject);
        end
    endtask

    task automatic test_malformed();
        req(4'b1100, 1'b1, 1'b0);
        checks++;
        if (reject !== 1'b1 || accept !== 1'b0 || count !== 12'hC03) begin
            failures++;
            $display("FAIL two_zero_sel rej=%b acc=%b count=%h want 1 0 C03", reject, accept, count);
        end
        idle();
        req(4'b1111, 1'b1, 1'b0);
        checks++;
        if (reject !== 1'b1 || accept !== 1'b0 || count !== 12'hC03) begin
            failures++;
            $display("FAIL no_sel rej=%b acc=%b count=%h want 1 0 C03", reject, accept, count);
        end
        idle();
        req(4'b1101, 1'b0, 1'b1);
        checks++;
        if (reject !== 1'b1 || accept !== 1'b0 || count !== 12'hC03) begin
            failures++;
            $display("FAIL undo_empty rej=%b acc=%b count=%h want 1 0 C03", reject, accept, count);
        end
        idle();
    endtask

    task automatic test_conflict_clear();
        req(4'b1110, 1'b1, 1'b1);
        checks++;
        if (reject !== 1'b1 || accept !== 1'b0 || count !== 12'hC03) begin
            failures++;
            $display("FAIL add_undo_same rej=%b acc=%b count=%h want 1 0 C03", reject, accept, count);
        end
        idle();
        clear = 1'b1;
        req(4'b1110, 1'b1, 1'b0);
        clear = 1'b0;
        checks++;
        if (count !== 12'h000 || row !== 3'd0 || accept !== 1'b0 || reject !== 1'b0 ||
            col_full !== 4'h0) begin
            failures++;
            $display("FAIL clear_with_add count=%h row=%0d acc=%b rej=%b full=%b want 000 0 0 0 0",
                     count, row, accept, reject, col_full);
        end
        idle();
    endtask

    task automatic test_hold();
        int n;
        n = 0;
        column = 4'b1110;
        add    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (accept === 1'b1) n++;
        end
        add = 1'b0;
        tick();
        checks++;
        if (n !== 1 || count !== 12'h001) begin
            failures++;
            $display("FAIL held_add accepts=%0d count=%h want 1 001", n, count);
        end
        reset = 1'b0;
        add   = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (accept === 1'b1) n++;
        end
        checks++;
        if (n !== 0 || count !== 12'h000) begin
            failures++;
            $display("FAIL add_through_reset accepts=%0d count=%h want 0 000", n, count);
        end
        idle();
        req(4'b1110, 1'b1, 1'b0);
        checks++;
        if (accept !== 1'b1 || count !== 12'h001) begin
            failures++;
            $display("FAIL add_after_reset acc=%b count=%h want 1 001", accept, count);
        end
        idle();
    endtask

    task automatic test_board_full();
        logic [3:0] col;
        int         n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int c = 0; c < 4; c++) begin
            col    = 4'hF;
            col[c] = 1'b0;
            for (int k = 0; k < 6; k++) begin
                req(col, 1'b1, 1'b0);
                idle();
            end
        end
        checks++;
        if (count !== 12'hDB6 || col_full !== 4'hF || board_full !== 1'b1 || row !== 3'd5) begin
            failures++;
            $display("FAIL board_full count=%h full=%b bfull=%b row=%0d want DB6 1111 1 5",
                     count, col_full, board_full, row);
        end
        req(4'b1101, 1'b0, 1'b1);
        checks++;
        if (accept !== 1'b1 || row !== 3'd5 || count[5:3] !== 3'd5 || board_full !== 1'b0 ||
            col_full !== 4'b1101) begin
            failures++;
            $display("FAIL undo_col1 acc=%b row=%0d c1=%0d bfull=%b full=%b want 1 5 5 0 1101",
                     accept, row, count[5:3], board_full, col_full);
        end
        idle();
        column = 4'b1110;
        undo   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 12'h000 || row !== 3'd0 || accept !== 1'b0 || reject !== 1'b0 ||
            col_full !== 4'h0 || board_full !== 1'b0) begin
            failures++;
            $display("FAIL async_reset count=%h row=%0d acc=%b rej=%b full=%b bfull=%b want all 0",
                     count, row, accept, reject, col_full, board_full);
        end
        tick();
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (accept === 1'b1 || reject === 1'b1) n++;
        end
        checks++;
        if (n !== 0 || count !== 12'h000) begin
            failures++;
            $display("FAIL post_reset_pulse pulses=%0d count=%h want 0 000", n, count);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_add_col0();
        test_fill_col3();
        test_malformed();
        test_conflict_clear();
        test_hold();
        test_board_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
